// File: rtl/mem_rob_hs.sv
// ---------------------------------------------------------------------------
// mem_rob_hs : memory reorder buffer between the CPU load port and an
// out-of-order, variable-latency memory.
//
// Each accepted CPU read is tagged with the index of a ROB entry (the
// allocation pointer). The request is passed straight through to memory.
// Responses may come back in any order and are parked in their entry. Data is
// handed back to the CPU strictly in request order from the retire pointer.
//
// Ports
//   clk, rstn                         clock, async active-low reset
//   cpu_req_valid/addr/ready          CPU read request
//   cpu_rsp_valid/data/ready          in-order read data to CPU
//   mem_req_valid/addr/id/ready       request to memory (id = entry index)
//   mem_rsp_valid/id/data             memory response (no backpressure)
//   occupancy                         allocated entries, 0..DEPTH
//   err_bad_id                        registered pulse: response hit a
//                                     FREE or DONE entry
//
// Optional build macro: MEM_ROB_HS_BYPASS_EN. When defined, a response to the
// head entry is forwarded combinationally to cpu_rsp_* in the same cycle.
//
// Handshake rule, identical on every interface: a transfer happens on a
// rising clk edge where valid && ready are both 1. A valid never waits for
// ready, and while valid=1 and ready=0 the payload is held stable.
// ---------------------------------------------------------------------------
module mem_rob_hs #(
   parameter  int DEPTH = 16,
   parameter  int AW    = 8,
   parameter  int DW    = 8,
   localparam int IDW   = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           cpu_req_valid,
   input  logic [AW-1:0]  cpu_req_addr,
   output logic           cpu_req_ready,
   output logic           cpu_rsp_valid,
   output logic [DW-1:0]  cpu_rsp_data,
   input  logic           cpu_rsp_ready,
   output logic           mem_req_valid,
   output logic [AW-1:0]  mem_req_addr,
   output logic [IDW-1:0] mem_req_id,
   input  logic           mem_req_ready,
   input  logic           mem_rsp_valid,
   input  logic [IDW-1:0] mem_rsp_id,
   input  logic [DW-1:0]  mem_rsp_data,
   output logic [IDW:0]   occupancy,
   output logic           err_bad_id
);

   typedef enum logic [1:0] {
      E_FREE = 2'd0,
      E_PEND = 2'd1,
      E_DONE = 2'd2
   } ent_st_t;

   localparam logic [IDW:0]   FULL_CNT = (IDW+1)'(DEPTH);
   localparam logic [IDW:0]   ONE_C    = (IDW+1)'(1);
   localparam logic [IDW-1:0] ONE_ID   = IDW'(1);

   ent_st_t        ent_st   [DEPTH];
   logic [DW-1:0]  ent_data [DEPTH];
   logic [IDW-1:0] tail;
   logic [IDW-1:0] head;
   logic [IDW:0]   count;

   logic full;
   logic alloc;
   logic rsp_hit;
   logic retire;

   // Full is decided by the registered count only, so a retire in the same
   // cycle does not reopen the request port until the next cycle.
   assign full = (count == FULL_CNT);

   // Gated by rstn so the request port is closed while reset is asserted.
   assign mem_req_valid = rstn && cpu_req_valid && !full;
   assign cpu_req_ready = rstn && mem_req_ready && !full;
   assign mem_req_addr  = cpu_req_addr;
   assign mem_req_id    = tail;

   assign alloc   = cpu_req_valid && cpu_req_ready;
   // The entry being allocated this cycle is still FREE, so a response to it
   // is rejected like any other stray ID.
   assign rsp_hit = mem_rsp_valid && (ent_st[mem_rsp_id] == E_PEND);

`ifdef MEM_ROB_HS_BYPASS_EN
   logic byp;
   assign byp           = rsp_hit && (mem_rsp_id == head);
   assign cpu_rsp_valid = (ent_st[head] == E_DONE) || byp;
   assign cpu_rsp_data  = byp ? mem_rsp_data : ent_data[head];
`else
   assign cpu_rsp_valid = (ent_st[head] == E_DONE);
   assign cpu_rsp_data  = ent_data[head];
`endif

   assign retire    = cpu_rsp_valid && cpu_rsp_ready;
   assign occupancy = count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tail       <= '0;
         head       <= '0;
         count      <= '0;
         err_bad_id <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_st[i]   <= E_FREE;
            ent_data[i] <= '0;
         end
      end else begin
         err_bad_id <= mem_rsp_valid && !rsp_hit;

         // Alloc targets a FREE entry, capture a PEND one and retire a DONE
         // one, so the three writes below touch distinct entries. The only
         // overlap is a bypassed retire, where the later FREE write wins.
         if (alloc) begin
            ent_st[tail] <= E_PEND;
            tail         <= tail + ONE_ID;
         end

         if (rsp_hit) begin
            ent_st[mem_rsp_id]   <= E_DONE;
            ent_data[mem_rsp_id] <= mem_rsp_data;
         end

         if (retire) begin
            ent_st[head] <= E_FREE;
            head         <= head + ONE_ID;
         end

         case ({alloc, retire})
            2'b10:   count <= count + ONE_C;
            2'b01:   count <= count - ONE_C;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_rob_hs.sv
// ---------------------------------------------------------------------------
// tb_mem_rob_hs : self-checking bench for mem_rob_hs.
//
// The reference model tracks outstanding requests as an ordered queue of IDs
// plus a per-ID status/data table. Every cycle the bench predicts all DUT
// outputs from it. A scoreboard queue (exp_q) holds the data the CPU must
// see retire, in order, during the directed sequences.
// ---------------------------------------------------------------------------
module tb_mem_rob_hs;

   localparam int DEPTH = 16;
   localparam int AW    = 8;
   localparam int DW    = 8;
   localparam int IDW   = 4;

   localparam int M_FREE = 0;
   localparam int M_PEND = 1;
   localparam int M_DONE = 2;

   logic           clk;
   logic           rstn;
   logic           cpu_req_valid;
   logic [AW-1:0]  cpu_req_addr;
   logic           cpu_req_ready;
   logic           cpu_rsp_valid;
   logic [DW-1:0]  cpu_rsp_data;
   logic           cpu_rsp_ready;
   logic           mem_req_valid;
   logic [AW-1:0]  mem_req_addr;
   logic [IDW-1:0] mem_req_id;
   logic           mem_req_ready;
   logic           mem_rsp_valid;
   logic [IDW-1:0] mem_rsp_id;
   logic [DW-1:0]  mem_rsp_data;
   logic [IDW:0]   occupancy;
   logic           err_bad_id;

   mem_rob_hs #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .cpu_req_valid (cpu_req_valid),
      .cpu_req_addr  (cpu_req_addr),
      .cpu_req_ready (cpu_req_ready),
      .cpu_rsp_valid (cpu_rsp_valid),
      .cpu_rsp_data  (cpu_rsp_data),
      .cpu_rsp_ready (cpu_rsp_ready),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_id    (mem_req_id),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_id    (mem_rsp_id),
      .mem_rsp_data  (mem_rsp_data),
      .occupancy     (occupancy),
      .err_bad_id    (err_bad_id)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running, required finished");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   int            order_q[$];      // outstanding IDs, oldest first
   int            m_st   [DEPTH];
   logic [DW-1:0] m_data [DEPTH];
   int            m_next;
   bit            m_err;

   logic [DW-1:0] exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      order_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         m_st[i]   = M_FREE;
         m_data[i] = '0;
      end
      m_next = 0;
      m_err  = 1'b0;
   endtask

   // One clock cycle: predict and check outputs for the inputs now applied,
   // advance the model, then move to just after the next rising edge.
   task automatic step();
      int            cnt;
      int            hid;
      bit            hit;
      bit            byp;
      bit            e_mem_valid;
      bit            e_req_ready;
      bit            e_rsp_valid;
      bit            e_alloc;
      bit            e_ret;
      logic [DW-1:0] e_rsp_data;
      #1;
      if (!rstn) model_reset();
      cnt = order_q.size();
      hid = (cnt > 0) ? order_q[0] : 0;
      e_mem_valid = rstn && cpu_req_valid && (cnt < DEPTH);
      e_req_ready = rstn && mem_req_ready && (cnt < DEPTH);
      hit = rstn && mem_rsp_valid && (m_st[int'(mem_rsp_id)] == M_PEND);
      byp = 1'b0;
`ifdef MEM_ROB_HS_BYPASS_EN
      byp = hit && (cnt > 0) && (int'(mem_rsp_id) == hid);
`endif
      e_rsp_valid = ((cnt > 0) && (m_st[hid] == M_DONE)) || byp;
      e_rsp_data  = byp ? mem_rsp_data : m_data[hid];

      check("mem_req_valid", 32'(mem_req_valid), 32'(e_mem_valid));
      check("cpu_req_ready", 32'(cpu_req_ready), 32'(e_req_ready));
      check("mem_req_id",    32'(mem_req_id),    32'(m_next));
      check("cpu_rsp_valid", 32'(cpu_rsp_valid), 32'(e_rsp_valid));
      check("occupancy",     32'(occupancy),     32'(cnt));
      check("err_bad_id",    32'(err_bad_id),    32'(m_err));
      if (rstn) check("mem_req_addr", 32'(mem_req_addr), 32'(cpu_req_addr));
      if (e_rsp_valid || !rstn) check("cpu_rsp_data", 32'(cpu_rsp_data), 32'(e_rsp_data));

      e_alloc = cpu_req_valid && e_req_ready;
      e_ret   = e_rsp_valid && cpu_rsp_ready;
      if (e_ret && exp_q.size() > 0) check("retire_order", 32'(cpu_rsp_data), 32'(exp_q.pop_front()));

      if (rstn) begin
         if (hit) begin
            m_st[int'(mem_rsp_id)]   = M_DONE;
            m_data[int'(mem_rsp_id)] = mem_rsp_data;
         end
         if (e_ret) begin
            m_st[hid] = M_FREE;
            void'(order_q.pop_front());
         end
         if (e_alloc) begin
            order_q.push_back(m_next);
            m_st[m_next] = M_PEND;
            m_next = (m_next + 1) % DEPTH;
         end
         m_err = mem_rsp_valid && !hit;
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      cpu_req_valid = 1'b0;
      cpu_req_addr  = '0;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0;
      mem_rsp_id    = '0;
      mem_rsp_data  = '0;
   endtask

   task automatic do_reset(input int cycles);
      rstn = 1'b0;
      for (int i = 0; i < cycles; i++) step();
      rstn = 1'b1;
   endtask

   task automatic req(input logic [AW-1:0] addr);
      cpu_req_valid = 1'b1;
      cpu_req_addr  = addr;
      mem_req_ready = 1'b1;
      step();
      cpu_req_valid = 1'b0;
   endtask

   task automatic rsp(input int id, input logic [DW-1:0] data);
      mem_rsp_valid = 1'b1;
      mem_rsp_id    = IDW'(id);
      mem_rsp_data  = data;
      step();
      mem_rsp_valid = 1'b0;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   // Answer every pending request in random order until the ROB is empty.
   task automatic drain();
      int pend_q[$];
      int budget;
      cpu_rsp_ready = 1'b1;
      cpu_req_valid = 1'b0;
      budget = 0;
      while (order_q.size() > 0 && budget < 300) begin
         pend_q.delete();
         for (int i = 0; i < DEPTH; i++) if (m_st[i] == M_PEND) pend_q.push_back(i);
         if (pend_q.size() > 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_id    = IDW'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
            mem_rsp_data  = DW'($urandom);
         end else begin
            mem_rsp_valid = 1'b0;
         end
         step();
         budget++;
      end
      mem_rsp_valid = 1'b0;
      check("drain_done", 32'(order_q.size()), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int pend_q[$];
      rstn          = 1'b0;
      cpu_rsp_ready = 1'b0;
      idle_inputs();
      model_reset();

      // In-order return of out-of-order responses.
      do_reset(3);
      req(8'h10);
      req(8'h20);
      req(8'h30);
      check("occ_after_3_req", 32'(occupancy), 32'd3);
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'hB2);
      exp_q.push_back(8'hC3);
      cpu_rsp_ready = 1'b1;
      rsp(2, 8'hC3);
      rsp(0, 8'hA1);
      rsp(1, 8'hB2);
      idle(4);
      check("occ_after_3_retire", 32'(occupancy), 32'd0);
      check("exp_q_empty_1", 32'(exp_q.size()), 32'd0);

      // Fill all entries, then retire one and see the wrapped ID accepted.
      do_reset(2);
      cpu_rsp_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) req(AW'(i * 3));
      check("occ_full", 32'(occupancy), 32'(DEPTH));
      cpu_req_valid = 1'b1;
      #1;
      check("full_req_ready", 32'(cpu_req_ready), 32'd0);
      exp_q.push_back(8'h5A);
      rsp(0, 8'h5A);
      cpu_req_valid = 1'b1;
      cpu_rsp_ready = 1'b1;
      step();                        // retire cycle: still full
      cpu_rsp_ready = 1'b0;
      #1;
      check("wrap_req_ready", 32'(cpu_req_ready), 32'd1);
      check("wrap_id", 32'(mem_req_id), 32'd0);
      step();
      cpu_req_valid = 1'b0;

      // Memory backpressure: no allocation.
      cpu_req_valid = 1'b1;
      mem_req_ready = 1'b0;
      idle(3);
      check("occ_backpressure", 32'(occupancy), 32'(DEPTH));
      cpu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      drain();

      // Head-of-line blocking and stable data under CPU backpressure.
      do_reset(2);
      cpu_rsp_ready = 1'b0;
      req(8'h01);
      req(8'h02);
      rsp(1, 8'h55);
      check("hol_blocked", 32'(cpu_rsp_valid), 32'd0);
      rsp(0, 8'h44);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", 32'(cpu_rsp_valid), 32'd1);
         check("hold_data", 32'(cpu_rsp_data), 32'h44);
         step();
      end
      exp_q.push_back(8'h44);
      exp_q.push_back(8'h55);
      cpu_rsp_ready = 1'b1;
      idle(2);
      check("occ_after_hold", 32'(occupancy), 32'd0);

      // Stray response to a FREE entry, then a duplicate to a DONE entry.
      rsp(7, 8'h77);
      check("err_free", 32'(err_bad_id), 32'd1);
      step();
      check("err_free_pulse", 32'(err_bad_id), 32'd0);
      cpu_rsp_ready = 1'b0;
      req(8'h40);                    // ID 2
      req(8'h50);                    // ID 3
      rsp(3, 8'h33);
      rsp(3, 8'hEE);
      check("err_dup", 32'(err_bad_id), 32'd1);
      check("occ_dup", 32'(occupancy), 32'd2);
      step();
      check("err_dup_pulse", 32'(err_bad_id), 32'd0);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      cpu_rsp_ready = 1'b1;
      rsp(2, 8'h22);
      idle(3);
      check("exp_q_empty_2", 32'(exp_q.size()), 32'd0);

      // Response to the head with the CPU ready: bypass or one-cycle path.
      req(8'h60);                    // ID 4
      mem_rsp_valid = 1'b1;
      mem_rsp_id    = IDW'(4);
      mem_rsp_data  = 8'h9E;
      #1;
`ifdef MEM_ROB_HS_BYPASS_EN
      check("byp_valid", 32'(cpu_rsp_valid), 32'd1);
      check("byp_data", 32'(cpu_rsp_data), 32'h9E);
`else
      check("nobyp_valid", 32'(cpu_rsp_valid), 32'd0);
`endif
      exp_q.push_back(8'h9E);
      step();
      mem_rsp_valid = 1'b0;
      idle(2);
      check("occ_after_byp", 32'(occupancy), 32'd0);
      check("exp_q_empty_3", 32'(exp_q.size()), 32'd0);

      // Randomized traffic with a reset in the middle.
      for (int cyc = 0; cyc < 2000; cyc++) begin
         cpu_req_valid = ($urandom_range(0, 99) < 60);
         cpu_req_addr  = AW'($urandom);
         mem_req_ready = ($urandom_range(0, 99) < 80);
         cpu_rsp_ready = ($urandom_range(0, 99) < 70);
         mem_rsp_data  = DW'($urandom);
         pend_q.delete();
         for (int i = 0; i < DEPTH; i++) if (m_st[i] == M_PEND) pend_q.push_back(i);
         if (pend_q.size() > 0 && $urandom_range(0, 99) < 50) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_id    = IDW'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
         end else if ($urandom_range(0, 99) < 5) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_id    = IDW'($urandom_range(0, DEPTH - 1));
         end else begin
            mem_rsp_valid = 1'b0;
         end
         if (cyc == 1000) begin
            rstn = 1'b0;
            step();
            step();
            rstn = 1'b1;
            mem_rsp_valid = 1'b1;      // late response from before reset
            mem_rsp_id    = IDW'(5);
            step();
            check("late_rsp_err", 32'(err_bad_id), 32'd1);
            mem_rsp_valid = 1'b0;
         end
         step();
      end
      idle_inputs();
      mem_req_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
